acc_datapath: RTL and testbench

//  Datapath of the multicycle accumulator CPU; sits directly downstream of the controller FSM.

---
 rtl/acc_datapath.sv | 86 ++++++++
 tb/tb_acc_datapath.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_datapath.sv
// acc_datapath: multicycle accumulator CPU datapath (PC, IR, MDR, AC, OPR, ALUR, flags, memory port)
module acc_datapath #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int PC_RESET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcWrite,
    input  logic              memAddressSel,
    input  logic              ACdataSel,
    input  logic              IRwriteSel,
    input  logic              memRead,
    input  logic              irWrite,
    input  logic              ACwrite,
    input  logic              ACread,
    input  logic              memWrite,
    input  logic [2:0]        ALUcommand,
    output logic [3:0]        upcode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ac_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              carry,
    output logic              zero
);
    logic [ADDR_W-1:0] pc, ir_addr;
    logic [3:0]        ir_op;
    logic [DATA_W-1:0] mdr, ac, opr, alur, alu_y;
    logic [DATA_W:0]   sum, diff;
    logic              alu_c, alu_cu;

    assign mem_addr  = memAddressSel ? ir_addr : pc;
    assign mem_wr    = memWrite;
    assign mem_rd    = memRead & ~memWrite;
    assign mem_wdata = opr;
    assign upcode    = ir_op;
    assign ac_out    = ac;
    assign pc_out    = pc;
    assign zero      = ac == '0;

    assign sum  = {1'b0, opr} + {1'b0, mdr};
    assign diff = {1'b0, opr} - {1'b0, mdr};

    // SUB carry is the inverted borrow out of the extended subtraction
    always_comb begin
        alu_cu = ALUcommand == 3'd0 || ALUcommand == 3'd2;
        alu_c  = ALUcommand == 3'd0 ? sum[DATA_W] : ~diff[DATA_W];
        alu_y  = opr;
        case (ALUcommand)
            3'd0: alu_y = sum[DATA_W-1:0];
            3'd1: alu_y = opr & mdr;
            3'd2: alu_y = diff[DATA_W-1:0];
            3'd3: alu_y = opr | mdr;
            3'd4: alu_y = opr ^ mdr;
            3'd5: alu_y = mdr;
            3'd6: alu_y = ~opr;
            default: alu_y = opr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= ADDR_W'(PC_RESET);
            ir_op   <= '0;
            ir_addr <= '0;
            mdr     <= '0;
            ac      <= '0;
            opr     <= '0;
            alur    <= '0;
            carry   <= 1'b0;
        end else begin
            if (pcWrite) pc <= pc + ADDR_W'(1);
            if (irWrite && !IRwriteSel) ir_op <= mem_rdata[DATA_W-1 -: 4];
            if (irWrite && IRwriteSel) ir_addr <= mem_rdata[ADDR_W-1:0];
            if (mem_rd) mdr <= mem_rdata;
            if (ACread) opr <= ac;
            if (ACwrite) ac <= ACdataSel ? alur : mdr;
            if (!ACwrite) alur <= alu_y;
            if (!ACwrite && alu_cu) carry <= alu_c;
        end
    end
endmodule

// File: tb/tb_acc_datapath.sv
// tb_acc_datapath: random and directed stimulus checked against a behavioural CPU-datapath model
module tb_acc_datapath;
    logic       clk = 1'b0, rst = 1'b1;
    logic       pcWrite, memAddressSel, ACdataSel, IRwriteSel, memRead, irWrite, ACwrite, ACread, memWrite;
    logic [2:0] ALUcommand;
    logic [3:0] upcode;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, ac_out, pc_out;
    logic       mem_rd, mem_wr, carry, zero;
    logic [7:0] mem [256];
    logic [7:0] mm [256];
    int m_pc, m_op, m_iaddr, m_mdr, m_ac, m_opr, m_alur, m_carry;
    int checks = 0, errors = 0;

    acc_datapath #(.DATA_W(8), .ADDR_W(8), .PC_RESET(0)) dut (
        .clk(clk), .rst(rst), .pcWrite(pcWrite), .memAddressSel(memAddressSel),
        .ACdataSel(ACdataSel), .IRwriteSel(IRwriteSel), .memRead(memRead), .irWrite(irWrite),
        .ACwrite(ACwrite), .ACread(ACread), .memWrite(memWrite), .ALUcommand(ALUcommand),
        .upcode(upcode), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ac_out(ac_out), .pc_out(pc_out),
        .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic void alu(input int cmd, input int a, input int b, output int y, output int c, output bit cu);
        cu = cmd == 0 || cmd == 2;
        c = 0;
        case (cmd)
            0: begin y = (a + b) % 256; c = (a + b) > 255; end
            1: y = a & b;
            2: begin y = (a - b + 256) % 256; c = a >= b; end
            3: y = a | b;
            4: y = a ^ b;
            5: y = b;
            6: y = 255 - a;
            default: y = a;
        endcase
    endfunction

    task automatic model_reset();
        {m_pc, m_op, m_iaddr, m_mdr, m_ac, m_opr, m_alur, m_carry} = '0;
    endtask

    // next state from the values present just before the clock edge
    task automatic model_step();
        int a, rd, y, c, old_ac, old_mdr, old_opr;
        bit cu;
        a = memAddressSel ? m_iaddr : m_pc;
        rd = mm[a];
        old_ac = m_ac; old_mdr = m_mdr; old_opr = m_opr;
        alu(int'(ALUcommand), old_opr, old_mdr, y, c, cu);
        if (memWrite) mm[a] = 8'(old_opr);
        if (ACread) m_opr = old_ac;
        if (ACwrite) m_ac = ACdataSel ? m_alur : old_mdr;
        else begin
            m_alur = y;
            if (cu) m_carry = c;
        end
        if (memRead && !memWrite) m_mdr = rd;
        if (irWrite && IRwriteSel) m_iaddr = rd;
        if (irWrite && !IRwriteSel) m_op = rd / 16;
        if (pcWrite) m_pc = (m_pc + 1) % 256;
    endtask

    always @(negedge clk) begin
        chk("pc", pc_out, m_pc);
        chk("upcode", upcode, m_op);
        chk("ac", ac_out, m_ac);
        chk("zero", zero, m_ac == 0);
        chk("carry", carry, m_carry);
        chk("mem_wdata", mem_wdata, m_opr);
        chk("mem_addr", mem_addr, memAddressSel ? m_iaddr : m_pc);
        chk("mem_rd", mem_rd, memRead & ~memWrite);
        chk("mem_wr", mem_wr, memWrite);
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic idle();
        {pcWrite, memAddressSel, ACdataSel, IRwriteSel, memRead, irWrite, ACwrite, ACread, memWrite} = '0;
        ALUcommand = 3'd0;
    endtask

    task automatic poke(input int a, input int v);
        mem[a] <= 8'(v);
        mm[a] = 8'(v);
    endtask

    task automatic fetch();
        idle(); memRead = 1; irWrite = 1; pcWrite = 1; tick();
        IRwriteSel = 1; tick();
        idle();
    endtask

    task automatic lda();
        idle(); memRead = 1; memAddressSel = 1; tick();
        idle(); ACwrite = 1; tick();
        idle();
    endtask

    task automatic alu_op(input int cmd);
        idle(); ACread = 1; memRead = 1; memAddressSel = 1; ALUcommand = 3'(cmd); tick();
        idle(); ALUcommand = 3'(cmd); tick();
        idle(); ACwrite = 1; ACdataSel = 1; tick();
    endtask

    task automatic rst_assert();
        idle();
        #2 rst = 1;
        model_reset();
        #1;
    endtask

    task automatic rst_release();
        tick();
        rst = 0;
    endtask

    initial begin
        idle();
        model_reset();
        for (int i = 0; i < 256; i++) poke(i, 0);
        tick(); tick();
        rst = 0;
        // fetch: opcode 2 then address 0x40
        poke(0, 8'h25); poke(1, 8'h40); poke(2, 8'h30); poke(3, 8'h41);
        poke(4, 8'h10); poke(5, 8'h42); poke(6, 8'h00); poke(7, 8'h40);
        poke(8'h40, 8'h37); poke(8'h42, 8'hF0);
        fetch();
        chk("fetch upcode", upcode, 2);
        chk("fetch pc", pc_out, 2);
        memAddressSel = 1; #1;
        chk("fetch ir_addr", mem_addr, 8'h40);
        lda();
        chk("lda ac", ac_out, 8'h37);
        fetch();
        idle(); ACread = 1; tick();
        idle(); memWrite = 1; memAddressSel = 1; #1;
        chk("sta mem_wr", mem_wr, 1);
        chk("sta addr", mem_addr, 8'h41);
        chk("sta wdata", mem_wdata, 8'h37);
        tick();
        idle(); #1;
        chk("sta stored", mem[8'h41], 8'h37);
        chk("sta wr low", mem_wr, 0);
        fetch(); lda();
        chk("ld F0", ac_out, 8'hF0);
        fetch();
        poke(8'h40, 8'h20);
        alu_op(0);
        chk("add ac", ac_out, 8'h10);
        chk("add carry", carry, 1);
        poke(8'h40, 8'h0F);
        alu_op(1);
        chk("and ac", ac_out, 8'h00);
        chk("and zero", zero, 1);
        chk("and carry held", carry, 1);
        poke(8'h40, 8'h5A);
        lda();
        chk("ld 5A", ac_out, 8'h5A);
        rst_assert();
        chk("rst ac", ac_out, 0);
        chk("rst pc", pc_out, 0);
        chk("rst upcode", upcode, 0);
        chk("rst mem_wr", mem_wr, 0);
        chk("rst zero", zero, 1);
        rst_release();
        idle(); pcWrite = 1;
        repeat (255) tick();
        chk("pc max", pc_out, 8'hFF);
        tick();
        chk("pc wrap", pc_out, 8'h00);
        idle(); memRead = 1; memWrite = 1; #1;
        chk("rw mem_rd", mem_rd, 0);
        chk("rw mem_wr", mem_wr, 1);
        tick();
        idle();
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_assert();
                rst_release();
            end else begin
                pcWrite = 1'($urandom_range(0, 1));
                memAddressSel = 1'($urandom_range(0, 1));
                ACdataSel = 1'($urandom_range(0, 1));
                IRwriteSel = 1'($urandom_range(0, 1));
                memRead = 1'($urandom_range(0, 1));
                irWrite = 1'($urandom_range(0, 1));
                ACwrite = $urandom_range(0, 2) == 0;
                ACread = 1'($urandom_range(0, 1));
                memWrite = $urandom_range(0, 3) == 0;
                ALUcommand = 3'($urandom_range(0, 7));
                tick();
            end
        end
        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
